cdb_arbiter: RTL and testbench
==============================

# cdb_arbiter

Common-data-bus transmitter for the out-of-order backend. Collects completed results from NUM_FU functional units through per-unit FIFOs, selects up to CDB_W results per cycle with round-robin fairness, and drives the registered CDB broadcast (valid/tag/value) consumed by the reservation stations, and the ROB tag consumed by the ROB. Sits between the execute units and every CDB listener.

## Interface
- NUM_FU, 4, number of functional-unit completion ports (≥ CDB_W)
- CDB_W, 2, number of CDB broadcast lanes
- PHYS_W, 6, physical register tag width
- FIFO_DEPTH, 2, per-FU result FIFO depth (power of two, ≥ 1)
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high
- flush  in  1  synchronous squash of all buffered and outgoing results
- fu_valid  in  [NUM_FU]  FU result valid
- fu_ready  out  [NUM_FU]  FIFO can accept; fu_ready[i] = (count[i] < FIFO_DEPTH)
- fu_tag  in  [NUM_FU][PHYS_W]  destination physical tag
- fu_value  in  [NUM_FU][64]  result value
- fu_rob_tag  in  [NUM_FU][6]  ROB index
- cdb_valid  out  [CDB_W]  lane valid (registered)
- cdb_tag  out  [CDB_W][PHYS_W]  broadcast tag (registered)
- cdb_value  out  [CDB_W][64]  broadcast value (registered)
- cdb_rob_tag  out  [CDB_W][6]  broadcast ROB index (registered)
- fifo_count  out  [NUM_FU][$clog2(FIFO_DEPTH+1)]  occupancy per FU, debug/perf

## Operation
- Enqueue: FU i result written to FIFO i at an edge where fu_valid[i] && fu_ready[i]; fu_valid without fu_ready is ignored (FU must hold).
- fu_ready depends only on registered count; no same-cycle pop-through when full.
- Eligible set: FUs with count[i] > 0; only FIFO heads are candidates, at most one result per FU per cycle.
- Selection: scan FU indices rr_ptr, rr_ptr+1, … mod NUM_FU; first eligible → lane 0, second → lane 1, up to CDB_W lanes. Unused lanes valid=0, tag/value/rob_tag=0.
- Granted heads popped at the same edge the CDB registers load.
- rr_ptr: if ≥1 grant, ← (index of last granted FU + 1) mod NUM_FU; otherwise unchanged.
- Simultaneous push and pop on same FIFO: both take effect, count unchanged.
- Per-FU ordering preserved (FIFO); no ordering across FUs.
- Flush (highest priority after reset): all counts and pointers ← 0, cdb_valid ← 0, rr_ptr ← 0; results pushed or granted in the flush cycle are discarded.
- Per-FU pointers wrap modulo FIFO_DEPTH.

## Timing
- Reset values: cdb_valid=0, cdb_tag=0, cdb_value=0, cdb_rob_tag=0, all counts=0, rr_ptr=0; fu_ready therefore all 1 out of reset.
- Latency: result accepted at edge k appears on cdb_* from edge k+1 (one cycle), if granted.
- cdb_* hold for exactly one cycle per grant; no backpressure from CDB listeners.
- fu_ready after flush/reset: 1 in the following cycle.
- Reset asserted mid-operation: all state cleared immediately (async); in-flight results lost.
- Throughput: CDB_W results/cycle peak; sustained per-FU rate 1/cycle when FIFO_DEPTH ≥ 2 and FU granted every cycle.

## Test plan
- Single result: reset, FU2 pushes tag=5, value=0xDEAD, rob=3 at edge 1 → edge 2 cdb_valid=2'b01, lane0 tag=5, value=0xDEAD, rob=3; edge 3 cdb_valid=0, fifo_count[2]=0.
- Contention: all 4 FUs push simultaneously at edge 1, rr_ptr=0 → edge 2 lanes carry FU0, FU1; edge 3 FU2, FU3; rr_ptr back to 0.
- Fairness: FU0 and FU1 push every cycle, FU3 pushes once → FU3 granted within 2 cycles; no FU starved over 100 random cycles; total results out = in.
- Backpressure: FU1 pushes 3 consecutive cycles with FU0,FU2,FU3 saturating lanes ahead of it → fu_ready[1]=0 once count=2, held result accepted later, FU1 outputs appear in push order.
- Flush: 4 FUs with count=2 each, assert flush one cycle → next cycle all fifo_count=0, cdb_valid=0, fu_ready=4'b1111; no stale result ever broadcast.
- Async reset mid-stream: assert reset between edges while cdb_valid=2'b11 → cdb_valid=0 immediately, all counts 0.

Source files
------------

// File: rtl/cdb_arbiter.sv
// Common-data-bus transmitter: per-FU result FIFOs feeding a round-robin
// selector that drives up to CDB_W registered broadcast lanes per cycle.
module cdb_arbiter #(
    parameter int NUM_FU     = 4,
    parameter int CDB_W      = 2,
    parameter int PHYS_W     = 6,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic                                        flush,
    input  logic [NUM_FU-1:0]                           fu_valid,
    output logic [NUM_FU-1:0]                           fu_ready,
    input  logic [NUM_FU-1:0][PHYS_W-1:0]               fu_tag,
    input  logic [NUM_FU-1:0][63:0]                     fu_value,
    input  logic [NUM_FU-1:0][5:0]                      fu_rob_tag,
    output logic [CDB_W-1:0]                            cdb_valid,
    output logic [CDB_W-1:0][PHYS_W-1:0]                cdb_tag,
    output logic [CDB_W-1:0][63:0]                      cdb_value,
    output logic [CDB_W-1:0][5:0]                       cdb_rob_tag,
    output logic [NUM_FU-1:0][$clog2(FIFO_DEPTH+1)-1:0] fifo_count
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int RW = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    logic [PHYS_W-1:0] r_tag_mem [NUM_FU][FIFO_DEPTH];
    logic [63:0]       r_val_mem [NUM_FU][FIFO_DEPTH];
    logic [5:0]        r_rob_mem [NUM_FU][FIFO_DEPTH];
    logic [PW-1:0]     r_rd_ptr  [NUM_FU];
    logic [PW-1:0]     r_wr_ptr  [NUM_FU];
    logic [CW-1:0]     r_count   [NUM_FU];
    logic [RW-1:0]     r_rr_ptr;

    logic [CDB_W-1:0]              r_cdb_valid;
    logic [CDB_W-1:0][PHYS_W-1:0]  r_cdb_tag;
    logic [CDB_W-1:0][63:0]        r_cdb_value;
    logic [CDB_W-1:0][5:0]         r_cdb_rob_tag;

    logic [NUM_FU-1:0]             w_push;
    logic [NUM_FU-1:0]             w_grant;
    logic [RW-1:0]                 w_rr_nxt;
    logic [CDB_W-1:0]              w_lane_vld;
    logic [CDB_W-1:0][PHYS_W-1:0]  w_lane_tag;
    logic [CDB_W-1:0][63:0]        w_lane_val;
    logic [CDB_W-1:0][5:0]         w_lane_rob;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [RW-1:0] fu_wrap(input logic [RW:0] s);
        return (s >= (RW+1)'(NUM_FU)) ? RW'(s - (RW+1)'(NUM_FU)) : RW'(s);
    endfunction

    always_comb begin
        for (int unsigned i = 0; i < NUM_FU; i++) begin
            fu_ready[i]   = (r_count[i] < CW'(FIFO_DEPTH));
            w_push[i]     = fu_valid[i] && fu_ready[i];
            fifo_count[i] = r_count[i];
        end
    end

    // Each lane takes the first not-yet-granted non-empty FIFO in scan order
    // from r_rr_ptr; repeating the scan per lane yields lanes in rr order.
    always_comb begin
        logic [RW-1:0] idx;
        logic          found;
        idx        = '0;
        found      = 1'b0;
        w_grant    = '0;
        w_lane_vld = '0;
        w_lane_tag = '0;
        w_lane_val = '0;
        w_lane_rob = '0;
        w_rr_nxt   = r_rr_ptr;
        for (int unsigned l = 0; l < CDB_W; l++) begin
            found = 1'b0;
            for (int unsigned off = 0; off < NUM_FU; off++) begin
                idx = fu_wrap({1'b0, r_rr_ptr} + (RW+1)'(off));
                if (!found && (r_count[idx] != '0) && !w_grant[idx]) begin
                    found         = 1'b1;
                    w_grant[idx]  = 1'b1;
                    w_lane_vld[l] = 1'b1;
                    w_lane_tag[l] = r_tag_mem[idx][r_rd_ptr[idx]];
                    w_lane_val[l] = r_val_mem[idx][r_rd_ptr[idx]];
                    w_lane_rob[l] = r_rob_mem[idx][r_rd_ptr[idx]];
                    w_rr_nxt      = fu_wrap({1'b0, idx} + 1'b1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NUM_FU; i++) begin
            if (w_push[i] && !flush) begin
                r_tag_mem[i][r_wr_ptr[i]] <= fu_tag[i];
                r_val_mem[i][r_wr_ptr[i]] <= fu_value[i];
                r_rob_mem[i][r_wr_ptr[i]] <= fu_rob_tag[i];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset || flush) begin
            for (int unsigned i = 0; i < NUM_FU; i++) begin
                r_rd_ptr[i] <= '0;
                r_wr_ptr[i] <= '0;
                r_count[i]  <= '0;
            end
            r_rr_ptr      <= '0;
            r_cdb_valid   <= '0;
            r_cdb_tag     <= '0;
            r_cdb_value   <= '0;
            r_cdb_rob_tag <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_FU; i++) begin
                if (w_push[i])
                    r_wr_ptr[i] <= ptr_inc(r_wr_ptr[i]);
                if (w_grant[i])
                    r_rd_ptr[i] <= ptr_inc(r_rd_ptr[i]);
                r_count[i] <= r_count[i] + CW'(w_push[i]) - CW'(w_grant[i]);
            end
            r_rr_ptr      <= w_rr_nxt;
            r_cdb_valid   <= w_lane_vld;
            r_cdb_tag     <= w_lane_tag;
            r_cdb_value   <= w_lane_val;
            r_cdb_rob_tag <= w_lane_rob;
        end
    end

    assign cdb_valid   = r_cdb_valid;
    assign cdb_tag     = r_cdb_tag;
    assign cdb_value   = r_cdb_value;
    assign cdb_rob_tag = r_cdb_rob_tag;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: a queue-based reference predicts each
// cycle's broadcast, popped and compared one cycle after the stimulus edge.
module tb_cdb_arbiter;

    typedef struct packed {
        logic [5:0]  tag;
        logic [63:0] val;
        logic [5:0]  rob;
    } ent_t;

    typedef struct packed {
        logic [1:0] v;
        ent_t       l1;
        ent_t       l0;
    } out_t;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             flush = 1'b0;
    logic [3:0]       fu_valid = '0;
    logic [3:0]       fu_ready;
    logic [3:0][5:0]  fu_tag = '0;
    logic [3:0][63:0] fu_value = '0;
    logic [3:0][5:0]  fu_rob_tag = '0;
    logic [1:0]       cdb_valid;
    logic [1:0][5:0]  cdb_tag;
    logic [1:0][63:0] cdb_value;
    logic [1:0][5:0]  cdb_rob_tag;
    logic [3:0][1:0]  fifo_count;

    always #5 clk = ~clk;

    cdb_arbiter #(.NUM_FU(4), .CDB_W(2), .PHYS_W(6), .FIFO_DEPTH(2)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .fu_valid(fu_valid), .fu_ready(fu_ready), .fu_tag(fu_tag),
        .fu_value(fu_value), .fu_rob_tag(fu_rob_tag),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .cdb_rob_tag(cdb_rob_tag), .fifo_count(fifo_count)
    );

    ent_t       mq[4][$];
    out_t       exp_q[$];
    logic [3:0] pv;
    ent_t       pd[4];
    int         rr;
    int         errors = 0;
    int         checks = 0;
    int         seq = 0;
    int         n_in, n_out;
    int         obs_fu[4];

    task automatic model_clear();
        for (int i = 0; i < 4; i++) mq[i].delete();
        exp_q.delete();
        rr = 0;
        pv = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        flush = 1'b0;
        fu_valid = '0;
        @(posedge clk); #1;
        reset = 1'b0;
        model_clear();
    endtask

    task automatic arm(input int i);
        pd[i].tag = {i[1:0], seq[3:0]};
        pd[i].val = {$urandom, $urandom};
        pd[i].rob = seq[5:0];
        pv[i] = 1'b1;
        seq++;
    endtask

    task automatic step(input logic fl);
        out_t       e, got;
        logic [3:0] rdy;
        int         n, last, idx;
        ent_t       x;
        for (int i = 0; i < 4; i++) begin
            fu_valid[i]   = pv[i];
            fu_tag[i]     = pd[i].tag;
            fu_value[i]   = pd[i].val;
            fu_rob_tag[i] = pd[i].rob;
        end
        flush = fl;
        for (int i = 0; i < 4; i++) rdy[i] = (mq[i].size() < 2);
        checks++;
        if (fu_ready !== rdy) begin
            errors++;
            $display("FAIL fu_ready: got %b expected %b", fu_ready, rdy);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (fifo_count[i] !== 2'(mq[i].size())) begin
                errors++;
                $display("FAIL fifo_count[%0d]: got %0d expected %0d", i, fifo_count[i], mq[i].size());
            end
        end
        e = '0;
        if (fl) begin
            for (int i = 0; i < 4; i++) mq[i].delete();
            rr = 0;
        end else begin
            n = 0;
            last = -1;
            for (int off = 0; off < 4; off++) begin
                idx = (rr + off) % 4;
                if (n < 2 && mq[idx].size() > 0) begin
                    x = mq[idx].pop_front();
                    if (n == 0) begin e.l0 = x; e.v[0] = 1'b1; end
                    else        begin e.l1 = x; e.v[1] = 1'b1; end
                    n++;
                    last = idx;
                end
            end
            if (last >= 0) rr = (last + 1) % 4;
            for (int i = 0; i < 4; i++) begin
                if (pv[i] && rdy[i]) begin
                    mq[i].push_back(pd[i]);
                    pv[i] = 1'b0;
                    n_in++;
                end
            end
        end
        exp_q.push_back(e);
        @(posedge clk); #1;
        flush = 1'b0;
        fu_valid = '0;
        e = exp_q.pop_front();
        got.v  = cdb_valid;
        got.l0 = {cdb_tag[0], cdb_value[0], cdb_rob_tag[0]};
        got.l1 = {cdb_tag[1], cdb_value[1], cdb_rob_tag[1]};
        checks++;
        if (got.v !== e.v) begin
            errors++;
            $display("FAIL cdb_valid: got %b expected %b", got.v, e.v);
        end
        checks++;
        if (got.l0 !== e.l0) begin
            errors++;
            $display("FAIL lane0: got tag=%h val=%h rob=%h expected tag=%h val=%h rob=%h",
                     got.l0.tag, got.l0.val, got.l0.rob, e.l0.tag, e.l0.val, e.l0.rob);
        end
        checks++;
        if (got.l1 !== e.l1) begin
            errors++;
            $display("FAIL lane1: got tag=%h val=%h rob=%h expected tag=%h val=%h rob=%h",
                     got.l1.tag, got.l1.val, got.l1.rob, e.l1.tag, e.l1.val, e.l1.rob);
        end
        if (cdb_valid[0] === 1'b1) begin n_out++; obs_fu[cdb_tag[0][5:4]]++; end
        if (cdb_valid[1] === 1'b1) begin n_out++; obs_fu[cdb_tag[1][5:4]]++; end
    endtask

    task automatic drain();
        logic busy;
        busy = 1'b1;
        for (int k = 0; k < 30 && busy; k++) begin
            busy = (pv != 4'b0);
            for (int i = 0; i < 4; i++) if (mq[i].size() > 0) busy = 1'b1;
            if (busy) step(1'b0);
        end
        checks++;
        if (busy) begin
            errors++;
            $display("FAIL drain_timeout: results still pending after 30 cycles");
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (cdb_valid !== 2'b00 || cdb_tag !== '0 || cdb_value !== '0 || cdb_rob_tag !== '0) begin
            errors++;
            $display("FAIL reset_cdb: got valid=%b tag=%h value=%h rob=%h expected all zero",
                     cdb_valid, cdb_tag, cdb_value, cdb_rob_tag);
        end
        checks++;
        if (fifo_count !== '0 || fu_ready !== 4'b1111) begin
            errors++;
            $display("FAIL reset_fifo: got count=%h ready=%b expected 0 / 1111", fifo_count, fu_ready);
        end
    endtask

    task automatic test_single();
        do_reset();
        pd[2] = '{tag: 6'd5, val: 64'hDEAD, rob: 6'd3};
        pv[2] = 1'b1;
        step(1'b0);
        step(1'b0);
        checks++;
        if (cdb_valid !== 2'b01 || cdb_tag[0] !== 6'd5 || cdb_value[0] !== 64'hDEAD || cdb_rob_tag[0] !== 6'd3) begin
            errors++;
            $display("FAIL single_out: got valid=%b tag=%0d value=%h rob=%0d expected 01/5/dead/3",
                     cdb_valid, cdb_tag[0], cdb_value[0], cdb_rob_tag[0]);
        end
        step(1'b0);
        checks++;
        if (cdb_valid !== 2'b00 || fifo_count[2] !== 2'd0) begin
            errors++;
            $display("FAIL single_after: got valid=%b count2=%0d expected 00/0", cdb_valid, fifo_count[2]);
        end
    endtask

    task automatic test_contention();
        logic [5:0] t[4];
        do_reset();
        for (int i = 0; i < 4; i++) begin arm(i); t[i] = pd[i].tag; end
        step(1'b0);
        step(1'b0);
        checks++;
        if (cdb_tag[0] !== t[0] || cdb_tag[1] !== t[1]) begin
            errors++;
            $display("FAIL contention_1: got %h,%h expected %h,%h", cdb_tag[0], cdb_tag[1], t[0], t[1]);
        end
        step(1'b0);
        checks++;
        if (cdb_tag[0] !== t[2] || cdb_tag[1] !== t[3]) begin
            errors++;
            $display("FAIL contention_2: got %h,%h expected %h,%h", cdb_tag[0], cdb_tag[1], t[2], t[3]);
        end
        arm(3); t[3] = pd[3].tag;
        arm(0); t[0] = pd[0].tag;
        step(1'b0);
        step(1'b0);
        checks++;
        if (cdb_tag[0] !== t[0] || cdb_tag[1] !== t[3]) begin
            errors++;
            $display("FAIL rr_wrap: got %h,%h expected %h,%h", cdb_tag[0], cdb_tag[1], t[0], t[3]);
        end
    endtask

    task automatic test_fairness();
        logic [5:0] t3;
        logic       seen;
        do_reset();
        arm(0); arm(1);
        step(1'b0);
        arm(0); arm(1); arm(3);
        t3 = pd[3].tag;
        step(1'b0);
        seen = 1'b0;
        for (int k = 0; k < 2; k++) begin
            if (!pv[0]) arm(0);
            if (!pv[1]) arm(1);
            step(1'b0);
            if ((cdb_valid[0] && cdb_tag[0] == t3) || (cdb_valid[1] && cdb_tag[1] == t3)) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b1) begin
            errors++;
            $display("FAIL fu3_grant: got seen=%b expected 1 within 2 cycles", seen);
        end
        drain();
    endtask

    task automatic test_random();
        do_reset();
        n_in = 0;
        n_out = 0;
        for (int i = 0; i < 4; i++) obs_fu[i] = 0;
        for (int c = 0; c < 100; c++) begin
            for (int i = 0; i < 4; i++) if (!pv[i] && $urandom_range(0, 1) == 1) arm(i);
            step(1'b0);
        end
        drain();
        checks++;
        if (n_out !== n_in) begin
            errors++;
            $display("FAIL conservation: got %0d results out expected %0d", n_out, n_in);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs_fu[i] == 0) begin
                errors++;
                $display("FAIL starvation[%0d]: got 0 grants expected >0", i);
            end
        end
    endtask

    task automatic test_backpressure();
        logic saw_nr;
        int   n1;
        do_reset();
        saw_nr = 1'b0;
        n1 = 0;
        for (int c = 0; c < 8; c++) begin
            if (!pv[0]) arm(0);
            if (!pv[2]) arm(2);
            if (!pv[3]) arm(3);
            if (!pv[1] && n1 < 4) begin arm(1); n1++; end
            step(1'b0);
            if (fu_ready[1] === 1'b0) saw_nr = 1'b1;
        end
        drain();
        checks++;
        if (saw_nr !== 1'b1) begin
            errors++;
            $display("FAIL fu1_backpressure: got saw_not_ready=%b expected 1", saw_nr);
        end
    endtask

    task automatic test_flush();
        do_reset();
        for (int c = 0; c < 5; c++) begin
            for (int i = 0; i < 4; i++) if (!pv[i]) arm(i);
            step(1'b0);
        end
        for (int i = 0; i < 4; i++) if (!pv[i]) arm(i);
        step(1'b1);
        pv = '0;
        checks++;
        if (fifo_count !== '0 || cdb_valid !== 2'b00 || fu_ready !== 4'b1111) begin
            errors++;
            $display("FAIL flush_state: got count=%h valid=%b ready=%b expected 0/00/1111",
                     fifo_count, cdb_valid, fu_ready);
        end
        for (int c = 0; c < 3; c++) step(1'b0);
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 4; i++) arm(i);
        step(1'b0);
        step(1'b0);
        checks++;
        if (cdb_valid !== 2'b11) begin
            errors++;
            $display("FAIL pre_reset_valid: got %b expected 11", cdb_valid);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (cdb_valid !== 2'b00 || fifo_count !== '0 || fu_ready !== 4'b1111) begin
            errors++;
            $display("FAIL async_reset: got valid=%b count=%h ready=%b expected 00/0/1111",
                     cdb_valid, fifo_count, fu_ready);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        model_clear();
        step(1'b0);
    endtask

    initial begin
        n_in = 0;
        n_out = 0;
        for (int i = 0; i < 4; i++) obs_fu[i] = 0;
        model_clear();
        test_reset();
        test_single();
        test_contention();
        test_fairness();
        test_backpressure();
        test_flush();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
